// File: rtl/if_id_queue.sv
// if_id_queue: circular IF/ID instruction FIFO; empty queue presents a NOP bubble to decode.
// Optional perf counters (ifq_full_cycles_o, ifq_flushes_o) enabled by macro IF_ID_QUEUE_PERF_EN.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_f_i,
  input  logic [INSTR_WIDTH-1:0] instr_f_i,
  input  logic [DATA_WIDTH-1:0]  pc_f_i,
  input  logic [DATA_WIDTH-1:0]  pc_plus_4_f_i,
  output logic                   stall_f_o,
  input  logic                   stall_d_i,
  input  logic                   flush_d_i,
  output logic                   valid_d_o,
  output logic [INSTR_WIDTH-1:0] instr_d_o,
  output logic [DATA_WIDTH-1:0]  pc_d_o,
`ifdef IF_ID_QUEUE_PERF_EN
  output logic [DATA_WIDTH-1:0]  pc_plus_4_d_o,
  output logic [31:0]            ifq_full_cycles_o,
  output logic [15:0]            ifq_flushes_o
`else
  output logic [DATA_WIDTH-1:0]  pc_plus_4_d_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0]  pc4_mem   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  always_comb begin
    stall_f_o     = count == FULL;
    valid_d_o     = count != '0;
    push          = valid_f_i & ~stall_f_o & ~flush_d_i;
    pop           = valid_d_o & ~stall_d_i & ~flush_d_i;
    instr_d_o     = valid_d_o ? instr_mem[rd_ptr] : NOP;
    pc_d_o        = valid_d_o ? pc_mem[rd_ptr] : '0;
    pc_plus_4_d_o = valid_d_o ? pc4_mem[rd_ptr] : '0;
  end
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_d_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_f_i;
      pc_mem[wr_ptr]    <= pc_f_i;
      pc4_mem[wr_ptr]   <= pc_plus_4_f_i;
    end
  end
`ifdef IF_ID_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ifq_full_cycles_o <= '0;
      ifq_flushes_o     <= '0;
    end else begin
      if (stall_f_o && ifq_full_cycles_o != '1) ifq_full_cycles_o <= ifq_full_cycles_o + 32'd1;
      if (flush_d_i && ifq_flushes_o != '1) ifq_flushes_o <= ifq_flushes_o + 16'd1;
    end
  end
`endif
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= FULL);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
endmodule
